// File: rtl/cross_bar_arbiter.sv
// Round-robin arbiter funnelling MASTER_N masters onto a single slave port.
// Read acceptances push the owning master index into an external order FIFO;
// slave read responses pop it to route the response strobe back in order.
module cross_bar_arbiter #(
    parameter int unsigned MASTER_N = 4,
    parameter int unsigned MAX_OUT  = 4,
    localparam int unsigned MASTER_W = (MASTER_N > 1) ? $clog2(MASTER_N) : 1,
    localparam int unsigned CNT_W    = $clog2(MAX_OUT + 1)
) (
    input  logic                clk,
    input  logic                aresetn,
    input  logic [MASTER_N-1:0] m_req,
    input  logic [MASTER_N-1:0] m_cmd,
    output logic [MASTER_N-1:0] m_ack,
    output logic [MASTER_N-1:0] m_resp,
    output logic                s_req,
    output logic                s_cmd,
    input  logic                s_ack,
    input  logic                s_resp,
    output logic [MASTER_W-1:0] grant_id,
    output logic                fifo_wr,
    output logic [MASTER_W-1:0] fifo_wdata,
    output logic                fifo_rd,
    input  logic [MASTER_W-1:0] fifo_rdata,
    input  logic                fifo_empty,
    output logic [CNT_W-1:0]    outstanding,
    output logic                resp_err
);

    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_REQ  = 1'b1;

    logic                r_state;
    logic [MASTER_W-1:0] r_grant_id;
    logic [MASTER_W-1:0] r_last_grant;
    logic [CNT_W-1:0]    r_outstanding;
    logic                r_resp_err;

    logic                w_full;
    logic [MASTER_N-1:0] w_elig;
    logic                w_found;
    logic [MASTER_W-1:0] w_pick;
    logic [MASTER_W-1:0] w_idx;
    logic                w_in_req;
    logic                w_accept;
    logic                w_rd_accept;
    logic                w_resp_ok;
    logic                w_resp_bad;
    logic                w_inc;
    logic                w_dec;

    // Reads are held off once the order FIFO could overflow; writes always pass.
    assign w_full = (r_outstanding == CNT_W'(MAX_OUT));
    assign w_elig = m_req & ~(m_cmd & {MASTER_N{w_full}});

    // Pick the first eligible master after the last one served, wrapping around.
    always_comb begin
        w_found = 1'b0;
        w_pick  = r_grant_id;
        w_idx   = '0;
        for (int unsigned k = 1; k <= MASTER_N; k++) begin
            w_idx = MASTER_W'((32'(r_last_grant) + k) % MASTER_N);
            if (!w_found && w_elig[w_idx]) begin
                w_found = 1'b1;
                w_pick  = w_idx;
            end
        end
    end

    // Combinational outputs are gated by aresetn so they read zero during reset.
    assign w_in_req    = aresetn && (r_state == ST_REQ);
    assign s_req       = w_in_req & m_req[r_grant_id];
    assign s_cmd       = w_in_req & m_cmd[r_grant_id];
    assign w_accept    = s_req & s_ack;
    assign w_rd_accept = w_accept & s_cmd;

    assign m_ack      = w_accept ? (MASTER_N'(1) << r_grant_id) : '0;
    assign fifo_wr    = w_rd_accept;
    assign fifo_wdata = w_rd_accept ? r_grant_id : '0;

    assign w_resp_ok  = aresetn & s_resp & ~fifo_empty;
    assign w_resp_bad = s_resp & fifo_empty;
    assign fifo_rd    = w_resp_ok;
    assign m_resp     = w_resp_ok ? (MASTER_N'(1) << fifo_rdata) : '0;

    assign w_inc = w_rd_accept && (r_outstanding != CNT_W'(MAX_OUT));
    assign w_dec = w_resp_ok && (r_outstanding != '0);

    assign grant_id    = r_grant_id;
    assign outstanding = r_outstanding;
    assign resp_err    = r_resp_err;

    // Two-state grant FSM; last_grant only moves on a completed handshake.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            r_state      <= ST_IDLE;
            r_grant_id   <= '0;
            r_last_grant <= MASTER_W'(MASTER_N - 1);
        end else if (r_state == ST_IDLE) begin
            if (w_found) begin
                r_grant_id <= w_pick;
                r_state    <= ST_REQ;
            end
        end else begin
            if (!m_req[r_grant_id]) begin
                r_state <= ST_IDLE;
            end else if (s_ack) begin
                r_last_grant <= r_grant_id;
                r_state      <= ST_IDLE;
            end
        end
    end

    // Outstanding read count; simultaneous accept and response cancel out.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            r_outstanding <= '0;
        end else if (w_inc && !w_dec) begin
            r_outstanding <= r_outstanding + CNT_W'(1);
        end else if (w_dec && !w_inc) begin
            r_outstanding <= r_outstanding - CNT_W'(1);
        end
    end

    // Sticky flag for a response that arrived with nothing to route it to.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            r_resp_err <= 1'b0;
        end else if (w_resp_bad) begin
            r_resp_err <= 1'b1;
        end
    end

endmodule

// File: doc/cross_bar_arbiter.md
CROSS_BAR_ARBITER -- requirements
Module: cross_bar_arbiter

Interface
REQ-001 Parameter MASTER_N, default 4: number of requesting masters; MASTER_W = $clog2(MASTER_N).
REQ-002 Parameter MAX_OUT, default 4: max outstanding reads; SHALL equal the depth of the attached order FIFO.
REQ-003 clk  input  1  clock, all state updates on rising edge.
REQ-004 aresetn  input  1  reset, asynchronous, active-low.
REQ-005 m_req  input  MASTER_N  per-master request; a master holds it until its m_ack.
REQ-006 m_cmd  input  MASTER_N  per-master command, 1 = read, 0 = write.
REQ-007 m_ack  output  MASTER_N  one-hot accept pulse to the granted master.
REQ-008 m_resp  output  MASTER_N  one-hot read-response strobe to the owning master.
REQ-009 s_req / s_cmd  output  1 / 1  request and command to the slave.
REQ-010 s_ack  input  1  slave accepts the current request.
REQ-011 s_resp  input  1  slave read-response strobe, single cycle.
REQ-012 grant_id  output  MASTER_W  registered index of the granted master.
REQ-013 fifo_wr / fifo_wdata  output  1 / MASTER_W  push of the accepted read's master index.
REQ-014 fifo_rd  output  1  pop of the order FIFO.
REQ-015 fifo_rdata / fifo_empty  input  MASTER_W / 1  head of the order FIFO and its empty flag.
REQ-016 outstanding  output  $clog2(MAX_OUT+1)  current count of accepted, unanswered reads.
REQ-017 resp_err  output  1  sticky flag for a response received with no outstanding read.

Function
REQ-018 FSM states SHALL be IDLE and REQ only.
REQ-019 Eligible masters: m_req[i]=1, excluding any master with m_cmd[i]=1 while outstanding==MAX_OUT.
REQ-020 IDLE with any eligible master: grant_id <= first eligible index searching last_grant+1, +2, ... modulo MASTER_N; next state REQ.
REQ-021 IDLE with no eligible master: stay in IDLE, grant_id unchanged.
REQ-022 In REQ: s_req = m_req[grant_id] and s_cmd = m_cmd[grant_id], combinationally; both SHALL be 0 in IDLE.
REQ-023 REQ with s_ack=1: m_ack[grant_id]=1 that cycle; last_grant <= grant_id; next state IDLE.
REQ-024 REQ with s_ack=1 and s_cmd=1: fifo_wr=1 and fifo_wdata=grant_id in the same cycle.
REQ-025 REQ with s_ack=0: stay in REQ and hold grant_id.
REQ-026 REQ with m_req[grant_id]=0 (master withdrew): return to IDLE; no m_ack, no fifo_wr, last_grant unchanged.
REQ-027 Latency: eligible request in IDLE cycle N gives s_req in cycle N+1; at most one acceptance per 2 cycles.
REQ-028 s_resp=1 with fifo_empty=0: fifo_rd=1 and m_resp[fifo_rdata]=1 in the same cycle.
REQ-029 s_resp=1 with fifo_empty=1: no fifo_rd, m_resp=0, and resp_err <= 1.
REQ-030 outstanding: +1 on read accept, -1 on valid response, unchanged when both occur in the same cycle; it SHALL never exceed MAX_OUT or underflow.
REQ-031 Write acceptances SHALL never change outstanding or the FIFO.

Reset
REQ-032 aresetn=0 SHALL immediately force: state IDLE, grant_id=0, last_grant=MASTER_N-1 (master 0 has first priority), outstanding=0, resp_err=0.
REQ-033 During reset all outputs SHALL be 0, including combinational m_ack, m_resp, s_req, fifo_wr and fifo_rd.
REQ-034 Reset asserted in REQ SHALL abort the transaction with no m_ack; resp_err SHALL clear only by reset.

Verification
REQ-035 m_req=0100, m_cmd=0100, s_ack=1 on first REQ cycle -> s_req at cycle+1, m_ack=0100, fifo_wr=1, fifo_wdata=2, outstanding=1.
REQ-036 m_req=1111 held, writes only, s_ack always 1 -> grant order 0,1,2,3,0, one m_ack every 2 cycles.
REQ-037 outstanding=4, m_req=1010, m_cmd=0010 -> master 3 granted, master 1 not granted until an s_resp drops outstanding to 3.
REQ-038 s_resp with fifo_rdata=2, concurrent read accept -> m_resp=0100, fifo_rd=1, outstanding unchanged.
REQ-039 s_resp with fifo_empty=1 -> fifo_rd=0, m_resp=0, resp_err=1 and held until aresetn=0.
REQ-040 aresetn=0 while in REQ with s_ack=0 -> s_req=0 immediately, no m_ack; after release master 0 wins a 1111 contest.
